// File: rtl/audio_pkg.sv
// audio_pkg: shared audio codec types and constants for the ADC capture and DAC tone paths
package audio_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int CNT_W = 5;
    localparam logic [15:0] MIDSCALE = 16'h8000;
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return &c ? c : c + 1'b1;
    endfunction
endpackage

// File: rtl/i2s_adc_receiver_if.sv
// i2s_adc_receiver_if: codec pins, control and sample outputs of the ADC capture path
interface i2s_adc_receiver_if
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic AUD_BCLK;
    logic AUD_ADCLRCK;
    logic AUD_ADCDAT;
    logic En;
    logic ErrClr;
    logic [DATA_WIDTH-1:0] SampleL;
    logic [DATA_WIDTH-1:0] SampleR;
    logic SampleValid;
    logic FrameErr;
    logic ErrSticky;
    modport master (
        input AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT, En, ErrClr,
        output SampleL, SampleR, SampleValid, FrameErr, ErrSticky
    );
    modport slave (
        output AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT, En, ErrClr,
        input SampleL, SampleR, SampleValid, FrameErr, ErrSticky
    );
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-FF synchroniser for an asynchronous pin with a third flop for edge detection
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic s1_q, s2_q, s3_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end
    assign dout = s2_q;
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;
endmodule

// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver: oversamples codec BCLK/LRCK/DAT on CLOCK_27 and emits one stereo PCM pair per frame
module i2s_adc_receiver
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter bit I2S_MODE     = 1'b0,
    parameter bit OUT_UNSIGNED = 1'b0
) (
    input logic CLOCK_27,
    input logic Reset,
    i2s_adc_receiver_if.master bus
);
    localparam logic [CNT_W-1:0] SKIP = CNT_W'(I2S_MODE);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_WIDTH + int'(I2S_MODE));
    localparam logic [DATA_WIDTH-1:0] FLIP = OUT_UNSIGNED ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : '0;

    logic bclk_rise, lrck_s, dat_s;
    logic edge_up, edge_dn, lr_edge, take;
    logic [CNT_W-1:0] slot, idx;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic lr_prev_q, lr_prev_d;
    logic seen_q, seen_d;
    logic lerr_q, lerr_d;
    logic pend_q, pend_d;
    logic perr_q, perr_d;
    logic valid_q, valid_d;
    logic ferr_q, ferr_d;
    logic sticky_q, sticky_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] sl_q, sl_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;

    sync_edge_det u_bclk (.clk(CLOCK_27), .rst(Reset), .din(bus.AUD_BCLK), .dout(), .rise(bclk_rise), .fall());
    sync_edge_det u_lrck (.clk(CLOCK_27), .rst(Reset), .din(bus.AUD_ADCLRCK), .dout(lrck_s), .rise(), .fall());
    sync_edge_det u_dat (.clk(CLOCK_27), .rst(Reset), .din(bus.AUD_ADCDAT), .dout(dat_s), .rise(), .fall());

    // channel edges are only trusted once a previous rise has registered LRCK
    assign edge_up = seen_q & lrck_s & ~lr_prev_q;
    assign edge_dn = seen_q & ~lrck_s & lr_prev_q;
    assign lr_edge = edge_up | edge_dn;
    assign slot = lr_edge ? '0 : cnt_q;
    assign idx = slot - SKIP;
    assign take = slot >= SKIP;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        lr_prev_d = lr_prev_q;
        seen_d = seen_q;
        lerr_d = lerr_q;
        sh_d = sh_q;
        left_d = left_q;
        sl_d = sl_q;
        sr_d = sr_q;
        pend_d = 1'b0;
        perr_d = 1'b0;
        valid_d = pend_q;
        ferr_d = perr_q;
        sticky_d = ferr_q | (sticky_q & ~bus.ErrClr);
        if (bclk_rise) begin
            lr_prev_d = lrck_s;
            seen_d = 1'b1;
            cnt_d = sat_inc(slot);
            sh_d = lr_edge ? '0 : sh_q;
            // bits land left-aligned so a short channel is zero-filled for free
            for (int i = 0; i < DATA_WIDTH; i++)
                if (take && int'(idx) == DATA_WIDTH - 1 - i) sh_d[i] = dat_s;
            if (state_q == IDLE && edge_up) state_d = LEFT;
            if (state_q == LEFT && edge_dn) begin
                state_d = RIGHT;
                left_d = sh_q;
                lerr_d = cnt_q != FULL;
            end
            if (state_q == RIGHT && edge_up) begin
                state_d = LEFT;
                sl_d = left_q ^ FLIP;
                sr_d = sh_q ^ FLIP;
                pend_d = 1'b1;
                perr_d = lerr_q | (cnt_q != FULL);
            end
        end
        if (!bus.En) state_d = IDLE;
    end

    always_ff @(posedge CLOCK_27) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            lr_prev_q <= 1'b0;
            seen_q <= 1'b0;
            lerr_q <= 1'b0;
            sh_q <= '0;
            left_q <= '0;
            sl_q <= '0;
            sr_q <= '0;
            pend_q <= 1'b0;
            perr_q <= 1'b0;
            valid_q <= 1'b0;
            ferr_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            lr_prev_q <= lr_prev_d;
            seen_q <= seen_d;
            lerr_q <= lerr_d;
            sh_q <= sh_d;
            left_q <= left_d;
            sl_q <= sl_d;
            sr_q <= sr_d;
            pend_q <= pend_d;
            perr_q <= perr_d;
            valid_q <= valid_d;
            ferr_q <= ferr_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.SampleL = sl_q;
    assign bus.SampleR = sr_q;
    assign bus.SampleValid = valid_q;
    assign bus.FrameErr = ferr_q;
    assign bus.ErrSticky = sticky_q;
endmodule

// File: tb/tb_i2s_adc_receiver.sv
// tb_i2s_adc_receiver: three receiver configurations fed the same codec waveform, checked by a frame-level scoreboard
module tb_i2s_adc_receiver;
    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic err;
        int cyc;
    } exp_t;

    logic clk = 0, rst = 1, bclk = 0, lrck = 0, dat = 0, en = 0, clr = 0;
    int cyc = 0, total = 0, bad = 0;
    exp_t q[3][$];
    logic [15:0] last_l[3], last_r[3];
    logic stk[3];
    logic [2:0] valid_w, ferr_w, stk_w;
    logic [15:0] sl_w[3], sr_w[3];
    logic have_prev = 0, cur_in = 0;
    logic [31:0] lv = 0, rv = 0;
    int ln = 16, rn = 16;
    int lens[5] = '{12, 16, 16, 17, 20};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        i2s_adc_receiver_if #(.DATA_WIDTH(16)) bus ();
        assign bus.AUD_BCLK = bclk;
        assign bus.AUD_ADCLRCK = lrck;
        assign bus.AUD_ADCDAT = dat;
        assign bus.En = en;
        assign bus.ErrClr = clr;
        assign valid_w[g] = bus.SampleValid;
        assign ferr_w[g] = bus.FrameErr;
        assign stk_w[g] = bus.ErrSticky;
        assign sl_w[g] = bus.SampleL;
        assign sr_w[g] = bus.SampleR;
        i2s_adc_receiver #(.DATA_WIDTH(16), .I2S_MODE(g == 2), .OUT_UNSIGNED(g == 1)) u_dut (
            .CLOCK_27(clk), .Reset(rst), .bus(bus));
    end

    task automatic check(string name, int g, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h", name, g, act, exp);
        end
    endtask

    // channel holds n slots sent MSB first; s leading skip slots carry no data
    function automatic logic [15:0] word(logic [31:0] v, int n, int s);
        int nd;
        logic [63:0] d;
        nd = n - s;
        d = {32'd0, v} & ((64'd1 << nd) - 64'd1);
        return nd >= 16 ? 16'(d >> (nd - 16)) : 16'(d << (16 - nd));
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            int s;
            s = (g == 2) ? 1 : 0;
            e.l = word(lv, ln, s) ^ ((g == 1) ? 16'h8000 : 16'h0);
            e.r = word(rv, rn, s) ^ ((g == 1) ? 16'h8000 : 16'h0);
            e.err = ((ln - s) != 16) || ((rn - s) != 16);
            e.cyc = cyc;
            q[g].push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (valid_w[g]) begin
                    if (q[g].size() == 0) check("unexpected_valid", g, 1, 0);
                    else begin
                        e = q[g].pop_front();
                        check("sample_l", g, sl_w[g], e.l);
                        check("sample_r", g, sr_w[g], e.r);
                        check("frame_err", g, ferr_w[g], e.err);
                        check("latency", g, cyc - e.cyc, 4);
                        last_l[g] = e.l;
                        last_r[g] = e.r;
                        if (e.err) stk[g] = 1;
                    end
                end else if (ferr_w[g]) check("stray_frame_err", g, 1, 0);
            end
        end
    endtask

    task automatic sticky_check();
        for (int g = 0; g < 3; g++) check("sticky_set", g, stk_w[g], stk[g]);
        clr = 1;
        @(negedge clk);
        clr = 0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("sticky_clr", g, stk_w[g], 0);
            stk[g] = 0;
        end
    endtask

    // act 1: reset pulse mid-channel, act 2: En dropped for 100 cycles
    task automatic send_chan(logic lr, logic [31:0] v, int n, int act);
        for (int k = 0; k < n; k++) begin
            bclk = 0;
            lrck = lr;
            dat = v[n-1-k];
            if (k == 6) sticky_check();
            if (k == 10 && act == 1) begin
                rst = 1;
                repeat (3) @(negedge clk);
                rst = 0;
                cur_in = 0;
                for (int g = 0; g < 3; g++) begin
                    last_l[g] = 0;
                    last_r[g] = 0;
                    stk[g] = 0;
                    check("rst_mid_l", g, sl_w[g], 0);
                    check("rst_mid_valid", g, valid_w[g], 0);
                end
            end
            if (k == 10 && act == 2) begin
                en = 0;
                repeat (100) @(negedge clk);
                en = 1;
                cur_in = 0;
                for (int g = 0; g < 3; g++) begin
                    check("hold_l", g, sl_w[g], last_l[g]);
                    check("hold_r", g, sr_w[g], last_r[g]);
                end
            end
            repeat (12) @(negedge clk);
            if (k == 0) begin
                if (lr) begin
                    if (have_prev && cur_in) push_frame();
                    cur_in = have_prev;
                    lv = v;
                    ln = n;
                end else begin
                    cur_in = have_prev && cur_in;
                    rv = v;
                    rn = n;
                end
                have_prev = 1;
            end
            bclk = 1;
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic send_frame(logic [31:0] a, int na, logic [31:0] b, int nb, int act);
        send_chan(1'b1, a, na, act);
        send_chan(1'b0, b, nb, 0);
    endtask

    function automatic logic [31:0] rnd(int n);
        return $urandom & ((32'd1 << n) - 32'd1);
    endfunction

    initial begin
        for (int g = 0; g < 3; g++) begin
            last_l[g] = 0;
            last_r[g] = 0;
            stk[g] = 0;
        end
        fork
            monitor();
        join_none
        repeat (4) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("rst_sample_l", g, sl_w[g], 0);
            check("rst_sample_r", g, sr_w[g], 0);
            check("rst_valid", g, valid_w[g], 0);
            check("rst_sticky", g, stk_w[g], 0);
        end
        rst = 0;
        en = 1;
        repeat (5) @(negedge clk);
        send_frame(rnd(16), 16, rnd(16), 16, 0);
        send_frame(32'h1234, 16, 32'hABCD, 16, 0);
        send_frame(32'h0000, 16, 32'hFFFF, 16, 0);
        send_frame(32'h18001, 17, rnd(17), 17, 0);
        send_frame(32'h0FFF, 12, rnd(16), 16, 0);
        send_frame(rnd(16), 16, rnd(16), 16, 1);
        send_frame(32'h5A5A, 16, 32'hA5A5, 16, 0);
        send_frame(rnd(16), 16, rnd(16), 16, 2);
        send_frame(rnd(16), 16, rnd(16), 16, 0);
        for (int i = 0; i < 10; i++) begin
            int na, nb;
            na = lens[$urandom_range(4)];
            nb = lens[$urandom_range(4)];
            send_frame(rnd(na), na, rnd(nb), nb, 0);
        end
        send_chan(1'b1, rnd(16), 16, 0);
        repeat (60) @(negedge clk);
        for (int g = 0; g < 3; g++) check("missing_valid", g, q[g].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
